control_unit: RTL and testbench

Microprogrammed control unit for the 16-bit accumulator CPU. It sequences fetch, decode and execute for each instruction and drives the 32-bit one-hot-per-action `control_signal` bus consumed by the ALU and the register/memory datapath. It is the producer side of the control word that the ALU decodes.

---
 rtl/control_unit.sv | 132 +++++++++++++
 tb/tb_control_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Microprogrammed fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Moore control word: one-hot-per-action bits decoded from the registered state and the latched opcode.
module control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ir_opcode,
    input  logic        acc_neg,
    input  logic        mem_ready,
    output logic [31:0] control_signal,
    output logic        halted,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,  ST_F1  = 4'd1,  ST_F2  = 4'd2,  ST_F3  = 4'd3,
        ST_F4   = 4'd4,  ST_DEC = 4'd5,  ST_E1  = 4'd6,  ST_E2  = 4'd7,
        ST_E3   = 4'd8,  ST_E4  = 4'd9,  ST_E5  = 4'd10, ST_S1  = 4'd11,
        ST_S2   = 4'd12, ST_JMP = 4'd13, ST_HLT = 4'd14, ST_BAD = 4'd15
    } state_t;

    localparam logic [7:0] OP_STORE  = 8'h01;
    localparam logic [7:0] OP_LOAD   = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGEZ = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;
    localparam logic [7:0] OP_MPY    = 8'h08;
    localparam logic [7:0] OP_AND    = 8'h0A;
    localparam logic [7:0] OP_OR     = 8'h0B;
    localparam logic [7:0] OP_NOT    = 8'h0C;
    localparam logic [7:0] OP_SHR    = 8'h0D;
    localparam logic [7:0] OP_SHL    = 8'h0E;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] op;

    // ALU operation bit for an opcode; zero for anything that is not an ALU op.
    function automatic logic [31:0] alu_word(input logic [7:0] o);
        logic [31:0] w;
        w = 32'h0;
        case (o)
            OP_ADD: w = 32'h0000_0200;
            OP_SUB: w = 32'h0000_0800;
            OP_MPY: w = 32'h0000_1000;
            OP_AND: w = 32'h0000_4000;
            OP_OR:  w = 32'h0000_8000;
            OP_NOT: w = 32'h0001_0000;
            OP_SHR: w = 32'h0002_0000;
            OP_SHL: w = 32'h0004_0000;
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op    <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == ST_DEC)
                op <= ir_opcode;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_F1;
            ST_F1:   state_nxt = ST_F2;
            ST_F2:   state_nxt = mem_ready ? ST_F3 : ST_F2;
            ST_F3:   state_nxt = ST_F4;
            ST_F4:   state_nxt = ST_DEC;
            ST_DEC: begin
                case (ir_opcode)
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
                    OP_MPY, OP_AND, OP_OR:      state_nxt = ST_E1;
                    OP_NOT, OP_SHR, OP_SHL:     state_nxt = ST_E5;
                    OP_JMP:                     state_nxt = ST_JMP;
                    OP_JMPGEZ:                  state_nxt = acc_neg ? ST_F1 : ST_JMP;
                    OP_HALT:                    state_nxt = ST_HLT;
                    default:                    state_nxt = ST_F1;
                endcase
            end
            ST_E1:   state_nxt = (op == OP_STORE) ? ST_S1 : ST_E2;
            ST_E2:   state_nxt = mem_ready ? ST_E3 : ST_E2;
            ST_E3:   state_nxt = ST_E4;
            ST_E4:   state_nxt = ST_E5;
            ST_E5:   state_nxt = ST_F1;
            ST_S1:   state_nxt = ST_S2;
            ST_S2:   state_nxt = mem_ready ? ST_F1 : ST_S2;
            ST_JMP:  state_nxt = ST_F1;
            ST_HLT:  state_nxt = ST_HLT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        control_signal = 32'h0;
        case (state)
            ST_F1:  control_signal[0]  = 1'b1;
            ST_F2:  control_signal[1]  = 1'b1;
            ST_F3: begin
                control_signal[2] = 1'b1;
                control_signal[5] = 1'b1;
            end
            ST_F4:  control_signal[3]  = 1'b1;
            ST_E1:  control_signal[4]  = 1'b1;
            ST_E2:  control_signal[1]  = 1'b1;
            ST_E3:  control_signal[2]  = 1'b1;
            ST_E4:  control_signal[6]  = 1'b1;
            ST_E5: begin
                // ACC<-ALU only accompanies a real ALU bit, so bit 10 never fires alone.
                if (op == OP_LOAD)
                    control_signal[21] = 1'b1;
                else if (alu_word(op) != 32'h0)
                    control_signal = alu_word(op) | 32'h0000_0400;
            end
            ST_S1:  control_signal[7]  = 1'b1;
            ST_S2:  control_signal[8]  = 1'b1;
            ST_JMP: control_signal[19] = 1'b1;
            ST_HLT: control_signal[20] = 1'b1;
            default: control_signal = 32'h0;
        endcase
    end

    assign halted    = (state == ST_HLT);
    assign state_dbg = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset walk, per-opcode timing and control words, waits, halt, async reset.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ir_opcode;
    logic        acc_neg;
    logic        mem_ready;
    logic [31:0] control_signal;
    logic        halted;
    logic [3:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    control_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ir_opcode      (ir_opcode),
        .acc_neg        (acc_neg),
        .mem_ready      (mem_ready),
        .control_signal (control_signal),
        .halted         (halted),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic        neg;
        logic [3:0]  stall_st;
        int          stall_n;
        logic        noise;
        int          len;
        logic [3:0]  cst;
        logic [31:0] cval;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic broken(input logic [31:0] cs);
        int n;
        n = $countones(cs & 32'h0007_DA00);
        return (n > 1) || (cs[10] != (n == 1)) || (cs[1] && cs[8])
               || (cs[31:22] != 10'h0) || cs[13];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts at F1; runs until the next F1 (or HLT), recording the OR of every word seen per state.
    task automatic run_instr(input vec_t v, output int len, output logic [31:0] seen_val, output int viol);
        logic [31:0] seen[16];
        int stall;
        stall = v.stall_n;
        len   = 0;
        viol  = 0;
        for (int i = 0; i < 16; i++) seen[i] = 32'h0;
        seen[state_dbg] = control_signal;
        do begin
            mem_ready = 1'b1;
            if (state_dbg == v.stall_st && stall > 0) begin
                mem_ready = 1'b0;
                stall--;
            end else if (v.noise && state_dbg != 4'd2 && state_dbg != 4'd7 && state_dbg != 4'd12)
                mem_ready = 1'($urandom_range(0, 1));
            if (state_dbg == 4'd5 || !v.noise) begin
                ir_opcode = v.op;
                acc_neg   = v.neg;
            end else begin
                ir_opcode = 8'($urandom);
                acc_neg   = 1'($urandom);
            end
            tick();
            len++;
            seen[state_dbg] |= control_signal;
            if (broken(control_signal)) viol++;
        end while (state_dbg != 4'd1 && state_dbg != 4'd14 && len < 40);
        seen_val = seen[v.cst];
    endtask

    initial begin
        int len;
        int viol;
        int hold_bad;
        logic [31:0] sv;
        logic [3:0]  walk_st[10];
        logic [31:0] walk_cs[10];

        rst_n = 1'b0; ir_opcode = 8'h03; acc_neg = 1'b0; mem_ready = 1'b1;
        walk_st = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
        walk_cs = '{32'h1, 32'h2, 32'h24, 32'h8, 32'h0, 32'h10, 32'h2, 32'h4, 32'h40, 32'h600};

        tick(); tick();
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_cs", control_signal, 32'h0);
        check("rst_halted", 32'(halted), 32'd0);

        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("walk_st%0d", i), 32'(state_dbg), 32'(walk_st[i]));
            check($sformatf("walk_cs%0d", i), control_signal, walk_cs[i]);
        end
        tick();
        check("add_f1_again", 32'(state_dbg), 32'd1);

        // F2 with mem_ready low for three sampled edges
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("f2_wait_st%0d", i), 32'(state_dbg), 32'd2);
            check($sformatf("f2_wait_cs%0d", i), control_signal, 32'h2);
        end
        mem_ready = 1'b1;
        ir_opcode = 8'h00;
        tick();
        check("f2_to_f3", 32'(state_dbg), 32'd3);
        len = 0;
        while (state_dbg != 4'd1 && len < 20) begin
            tick();
            len++;
        end
        check("nop_after_wait", 32'(len), 32'd3);

        //                op     neg   stall  n  noise len cst    cval
        vecs.push_back('{8'h03, 1'b0, 4'd0,  0, 1'b1, 10, 4'd10, 32'h0000_0600});
        vecs.push_back('{8'h04, 1'b0, 4'd0,  0, 1'b0, 10, 4'd10, 32'h0000_0C00});
        vecs.push_back('{8'h08, 1'b0, 4'd7,  2, 1'b0, 12, 4'd10, 32'h0000_1400});
        vecs.push_back('{8'h0A, 1'b0, 4'd0,  0, 1'b1, 10, 4'd10, 32'h0000_4400});
        vecs.push_back('{8'h0B, 1'b0, 4'd0,  0, 1'b0, 10, 4'd10, 32'h0000_8400});
        vecs.push_back('{8'h0C, 1'b0, 4'd0,  0, 1'b0,  6, 4'd10, 32'h0001_0400});
        vecs.push_back('{8'h0D, 1'b0, 4'd0,  0, 1'b1,  6, 4'd10, 32'h0002_0400});
        vecs.push_back('{8'h0E, 1'b0, 4'd0,  0, 1'b0,  6, 4'd10, 32'h0004_0400});
        vecs.push_back('{8'h02, 1'b0, 4'd7,  1, 1'b0, 11, 4'd10, 32'h0020_0000});
        vecs.push_back('{8'h01, 1'b0, 4'd12, 2, 1'b0, 10, 4'd12, 32'h0000_0100});
        vecs.push_back('{8'h01, 1'b0, 4'd0,  0, 1'b1,  8, 4'd11, 32'h0000_0080});
        vecs.push_back('{8'h06, 1'b0, 4'd0,  0, 1'b0,  6, 4'd13, 32'h0008_0000});
        vecs.push_back('{8'h05, 1'b0, 4'd0,  0, 1'b0,  6, 4'd13, 32'h0008_0000});
        vecs.push_back('{8'h05, 1'b1, 4'd0,  0, 1'b0,  5, 4'd13, 32'h0000_0000});
        vecs.push_back('{8'hFF, 1'b0, 4'd0,  0, 1'b0,  5, 4'd10, 32'h0000_0000});
        vecs.push_back('{8'h00, 1'b0, 4'd0,  0, 1'b1,  5, 4'd6,  32'h0000_0000});
        vecs.push_back('{8'h07, 1'b0, 4'd2,  1, 1'b0,  6, 4'd14, 32'h0010_0000});

        foreach (vecs[k]) begin
            run_instr(vecs[k], len, sv, viol);
            check($sformatf("len_op%02h_%0d", vecs[k].op, k), 32'(len), 32'(vecs[k].len));
            check($sformatf("cw_op%02h_%0d", vecs[k].op, k), sv, vecs[k].cval);
            check($sformatf("inv_op%02h_%0d", vecs[k].op, k), 32'(viol), 32'd0);
        end
        check("halt_state", 32'(state_dbg), 32'd14);

        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom);
            ir_opcode = 8'($urandom);
            tick();
            if (control_signal !== 32'h0010_0000 || halted !== 1'b1 || state_dbg !== 4'd14)
                hold_bad++;
        end
        check("halt_hold", 32'(hold_bad), 32'd0);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cs", control_signal, 32'h0);
        check("async_rst_halted", 32'(halted), 32'd0);
        check("async_rst_state", 32'(state_dbg), 32'd0);

        @(negedge clk);
        mem_ready = 1'b1; ir_opcode = 8'h03; acc_neg = 1'b0;
        rst_n = 1'b1;
        tick();
        check("restart_f1", 32'(state_dbg), 32'd1);
        len = 0;
        while (state_dbg != 4'd10 && len < 20) begin
            tick();
            len++;
        end
        check("reach_e5", 32'(state_dbg), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        check("e5_rst_cs", control_signal, 32'h0);
        tick();
        check("e5_rst_hold_cs", control_signal, 32'h0);
        check("e5_rst_hold_st", 32'(state_dbg), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
